// File: rtl/audio_pkg.sv
// Shared audio link types for the codec DAC transmitter and ADC receiver.
// Frame layout, justification modes and transmitter states.
package audio_pkg;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_frame_t;

  localparam int MODE_LJ  = 0;
  localparam int MODE_I2S = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT
  } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO clocked on the falling bit-clock edge.
// Show-ahead read port; push/pop are ignored when full/empty.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (o_level == LW'(DEPTH));
  assign o_empty = (o_level == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  always_ff @(negedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  // Pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)
        o_level <= o_level + LW'(1);
      else if (pop_ok && !push_ok)
        o_level <= o_level - LW'(1);
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// Codec DAC serializer: buffers stereo frames and shifts them MSB-first
// onto DACDAT, framed by DACLRCK, on the falling bit-clock edge.
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_mute,
  input  logic                          i_daclrck,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_left,
  input  logic [DATA_WIDTH-1:0]         i_right,
  output logic                          o_ready,
  output logic                          o_dacdat,
  output logic                          o_underrun,
  output logic [7:0]                    o_underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  tx_state_t         state;
  tx_state_t         state_nx;
  logic              fetch;
  logic              load_right;
  logic              lrck_q;
  logic              lrck_v;
  logic              lrck_edge;
  logic              lrck_fall;
  logic              lrck_rise;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*DW-1:0]   fifo_rd;
  logic [DW-1:0]     right_q;
  logic [DW-1:0]     sreg;
  logic [DW-1:0]     slot_word;
  logic [CW-1:0]     bits;
  logic              push;
  logic              pop;
  logic              starve;

  assign lrck_edge = lrck_v & (i_daclrck ^ lrck_q);
  assign lrck_fall = lrck_edge & ~i_daclrck;
  assign lrck_rise = lrck_edge & i_daclrck;

  assign o_ready = ~fifo_full;
  assign push    = i_valid & o_ready;
  assign pop     = fetch & ~fifo_empty;
  assign starve  = fetch & fifo_empty;

  assign slot_word = fetch
                   ? (fifo_empty ? '0 : fifo_rd[2*DW-1:DW])
                   : right_q;

  sample_fifo #(
    .WIDTH (2*DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  ({i_left, i_right}),
    .i_pop   (pop),
    .o_data  (fifo_rd),
    .o_level (o_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // LRCK history; the first sample after reset only arms the detector.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrck_q <= 1'b0;
      lrck_v <= 1'b0;
    end else begin
      lrck_q <= i_daclrck;
      lrck_v <= 1'b1;
    end
  end

  // Slot state register.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Slot sequencing: a frame is fetched on each falling LRCK edge.
  always_comb begin
    state_nx   = state;
    fetch      = 1'b0;
    load_right = 1'b0;
    if (!i_en) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (lrck_fall) begin
            state_nx = S_LEFT;
            fetch    = 1'b1;
          end
        end
        S_LEFT: begin
          if (lrck_rise) begin
            state_nx   = S_RIGHT;
            load_right = 1'b1;
          end
        end
        S_RIGHT: begin
          if (lrck_fall) begin
            state_nx = S_LEFT;
            fetch    = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Underrun pulse and saturating count on starved fetches.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      o_underrun <= starve;
      if (starve && o_underrun_cnt != 8'hFF)
        o_underrun_cnt <= o_underrun_cnt + 8'd1;
    end
  end

  // Serializer: left-justified emits the MSB on the slot edge,
  // I2S emits a zero there and the MSB one bit clock later.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      right_q  <= '0;
      sreg     <= '0;
      bits     <= '0;
      o_dacdat <= 1'b0;
    end else begin
      if (fetch)
        right_q <= fifo_empty ? '0 : fifo_rd[DW-1:0];
      if (!i_en) begin
        sreg     <= '0;
        bits     <= '0;
        o_dacdat <= 1'b0;
      end else if (fetch || load_right) begin
        if (MODE == MODE_LJ) begin
          o_dacdat <= slot_word[DW-1] & ~i_mute;
          sreg     <= slot_word << 1;
          bits     <= CW'(DW - 1);
        end else begin
          o_dacdat <= 1'b0;
          sreg     <= slot_word;
          bits     <= CW'(DW);
        end
      end else if (bits != '0) begin
        o_dacdat <= sreg[DW-1] & ~i_mute;
        sreg     <= sreg << 1;
        bits     <= bits - CW'(1);
      end else begin
        o_dacdat <= 1'b0;
      end
    end
  end

endmodule
